// File: rtl/snake_pkg.sv
// Shared Snake definitions: movement encodings, PS/2 Set-2 scancodes and
// the movement_encoder FSM state type.
package snake_pkg;

  localparam int unsigned MV_W   = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned KC_W   = 32;

  localparam logic [MV_W-1:0] MV_RIGHT = 3'b000;
  localparam logic [MV_W-1:0] MV_UP    = 3'b001;
  localparam logic [MV_W-1:0] MV_LEFT  = 3'b010;
  localparam logic [MV_W-1:0] MV_DOWN  = 3'b011;

  localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_BREAK = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_RIGHT = 8'h74;
  localparam logic [BYTE_W-1:0] SC_UP    = 8'h75;
  localparam logic [BYTE_W-1:0] SC_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_DOWN  = 8'h72;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MK_E0   = 3'd1,
    MK_CODE = 3'd2,
    BR_E0   = 3'd3,
    BR_F0   = 3'd4,
    BR_CODE = 3'd5
  } enc_state_e;

endpackage

// File: rtl/mv_scancode_lut.sv
// Combinational map from a movement command to its arrow-key scancode.
module mv_scancode_lut
  import snake_pkg::*;
(
  input  logic [MV_W-1:0]   movement_i,
  output logic              legal_c_o,
  output logic [BYTE_W-1:0] code_c_o
);

  // Decode the four legal movements; anything with bit 2 set is illegal.
  always_comb begin
    legal_c_o = 1'b1;
    code_c_o  = 8'h00;
    case (movement_i)
      MV_RIGHT: code_c_o = SC_RIGHT;
      MV_UP:    code_c_o = SC_UP;
      MV_LEFT:  code_c_o = SC_LEFT;
      MV_DOWN:  code_c_o = SC_DOWN;
      default: begin
        legal_c_o = 1'b0;
        code_c_o  = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/movement_encoder.sv
// Movement command to PS/2 Set-2 extended arrow-key byte stream.
// Macro SCAN_BREAK_EN: when defined, each command emits make + break
// (E0 code E0 F0 code); otherwise make only (E0 code).
module movement_encoder
  import snake_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mv_valid,
  output logic              mv_ready,
  input  logic [MV_W-1:0]   movement,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_data,
  output logic [KC_W-1:0]   keycode,
  output logic              err
);

  enc_state_e        state_q, state_d;
  logic [BYTE_W-1:0] code_q, code_d;
  logic              mv_ready_q, mv_ready_d;
  logic              byte_valid_q, byte_valid_d;
  logic [BYTE_W-1:0] byte_data_q, byte_data_d;
  logic [KC_W-1:0]   keycode_q, keycode_d;
  logic              err_q, err_d;

  logic              lut_legal;
  logic [BYTE_W-1:0] lut_code;
  logic              hs;

  mv_scancode_lut u_lut (
    .movement_i (movement),
    .legal_c_o  (lut_legal),
    .code_c_o   (lut_code)
  );

  assign hs = byte_valid_q & byte_ready;

  // Next state, latched code, history shift and next registered outputs.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    keycode_d = keycode_q;
    err_d     = 1'b0;

    if (hs) begin
      keycode_d = {keycode_q[KC_W-BYTE_W-1:0], byte_data_q};
    end

    case (state_q)
      IDLE: begin
        if (mv_valid) begin
          if (lut_legal) begin
            code_d  = lut_code;
            state_d = MK_E0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MK_E0: begin
        if (hs) state_d = MK_CODE;
      end
`ifdef SCAN_BREAK_EN
      MK_CODE: begin
        if (hs) state_d = BR_E0;
      end
      BR_E0: begin
        if (hs) state_d = BR_F0;
      end
      BR_F0: begin
        if (hs) state_d = BR_CODE;
      end
      BR_CODE: begin
        if (hs) state_d = IDLE;
      end
`else
      MK_CODE: begin
        if (hs) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    mv_ready_d   = (state_d == IDLE);
    byte_valid_d = (state_d != IDLE);
    case (state_d)
      MK_E0:   byte_data_d = SC_EXT;
      MK_CODE: byte_data_d = code_d;
      BR_E0:   byte_data_d = SC_EXT;
      BR_F0:   byte_data_d = SC_BREAK;
      BR_CODE: byte_data_d = code_d;
      default: byte_data_d = 8'h00;
    endcase
  end

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      code_q       <= 8'h00;
      mv_ready_q   <= 1'b1;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      keycode_q    <= 32'h0000_0000;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      mv_ready_q   <= mv_ready_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      keycode_q    <= keycode_d;
      err_q        <= err_d;
    end
  end

  assign mv_ready   = mv_ready_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign keycode    = keycode_q;
  assign err        = err_q;

endmodule

// File: tb/tb_movement_encoder.sv
// Scoreboard bench for movement_encoder; works with or without SCAN_BREAK_EN.
module tb_movement_encoder;

`ifdef SCAN_BREAK_EN
  localparam int SEQ_LEN = 5;
  localparam int ABORT_AFTER = 3;
`else
  localparam int SEQ_LEN = 2;
  localparam int ABORT_AFTER = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mv_valid = 1'b0;
  logic [2:0]  movement = 3'b000;
  logic        byte_ready = 1'b1;
  logic        mv_ready;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [31:0] keycode;
  logic        err;

  int checks = 0;
  int passes = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] model_kc = 32'h0;

  movement_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mv_valid   (mv_valid),
    .mv_ready   (mv_ready),
    .movement   (movement),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .keycode    (keycode),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] code_of(input logic [2:0] m);
    case (m)
      3'b000:  return 8'h74;
      3'b001:  return 8'h75;
      3'b010:  return 8'h6B;
      3'b011:  return 8'h72;
      default: return 8'h00;
    endcase
  endfunction

  // Monitor: every accepted byte is compared against the scoreboard queue.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      exp_q.delete();
      model_kc = 32'h0;
    end else if (byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_byte: got %h expected no byte", byte_data);
      end else begin
        e = exp_q.pop_front();
        chk("byte_data", {24'h0, byte_data}, {24'h0, e});
        chk("keycode_before_hs", keycode, model_kc);
        model_kc = {model_kc[23:0], e};
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Offer one command; returns 1ns after the accepting edge.
  task automatic send(input logic [2:0] m, input bit legal);
    int n = 0;
    while (!mv_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready_timeout", {31'h0, mv_ready}, 32'h1);
    movement = m;
    mv_valid = 1'b1;
    if (legal) begin
      exp_q.push_back(8'hE0);
      exp_q.push_back(code_of(m));
`ifdef SCAN_BREAK_EN
      exp_q.push_back(8'hE0);
      exp_q.push_back(8'hF0);
      exp_q.push_back(code_of(m));
`endif
    end
    @(posedge clk); #1;
    mv_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(mv_ready && exp_q.size() == 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", {31'h0, (n < 200)}, 32'h1);
  endtask

  initial begin
    do_reset();

    // Reset state
    chk("rst_mv_ready", {31'h0, mv_ready}, 32'h1);
    chk("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
    chk("rst_byte_data", {24'h0, byte_data}, 32'h0);
    chk("rst_keycode", keycode, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);

    // Left, byte_ready high: first byte right after accept, back-to-back bytes
    send(3'b010, 1'b1);
    chk("latency_data", {24'h0, byte_data}, 32'hE0);
    for (int i = 0; i < SEQ_LEN; i++) begin
      chk("left_consecutive", {31'h0, byte_valid}, 32'h1);
      @(posedge clk); #1;
    end
    chk("left_mv_ready_after", {31'h0, mv_ready}, 32'h1);
    chk("left_byte_valid_after", {31'h0, byte_valid}, 32'h0);
`ifdef SCAN_BREAK_EN
    chk("left_keycode", keycode, 32'h6BE0F06B);
`else
    chk("left_keycode", keycode, 32'h0000E06B);
`endif

    // Up from reset
    do_reset();
    send(3'b001, 1'b1);
    wait_idle();
`ifdef SCAN_BREAK_EN
    chk("up_keycode", keycode, 32'h75E0F075);
`else
    chk("up_keycode", keycode, 32'h0000E075);
`endif

    // Down with 3 cycles of backpressure on the 0x72 byte
    send(3'b011, 1'b1);
    @(posedge clk); #1;
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_data", {24'h0, byte_data}, 32'h72);
      chk("bp_valid", {31'h0, byte_valid}, 32'h1);
`ifdef SCAN_BREAK_EN
      chk("bp_keycode", keycode, 32'hE0F075E0);
`else
      chk("bp_keycode", keycode, 32'h00E075E0);
`endif
    end
    byte_ready = 1'b1;
    wait_idle();
`ifdef SCAN_BREAK_EN
    chk("down_keycode", keycode, 32'h72E0F072);
`else
    chk("down_keycode", keycode, 32'hE075E072);
`endif

    // Illegal then Right
    do_reset();
    send(3'b101, 1'b0);
    chk("ill_err_pulse", {31'h0, err}, 32'h1);
    chk("ill_no_byte", {31'h0, byte_valid}, 32'h0);
    chk("ill_mv_ready", {31'h0, mv_ready}, 32'h1);
    @(posedge clk); #1;
    chk("ill_err_cleared", {31'h0, err}, 32'h0);
    chk("ill_keycode", keycode, 32'h0);
    send(3'b000, 1'b1);
    chk("right_no_err", {31'h0, err}, 32'h0);
    wait_idle();
`ifdef SCAN_BREAK_EN
    chk("right_keycode", keycode, 32'h74E0F074);
`else
    chk("right_keycode", keycode, 32'h0000E074);
`endif

    // Reset in the middle of a sequence
    do_reset();
    send(3'b010, 1'b1);
    repeat (ABORT_AFTER) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_byte_valid", {31'h0, byte_valid}, 32'h0);
    chk("abort_keycode", keycode, 32'h0);
    chk("abort_mv_ready", {31'h0, mv_ready}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("abort_no_bytes", {31'h0, byte_valid}, 32'h0);
    end
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/movement_encoder.md
# movement_encoder

Converts a 3-bit Snake movement command into the PS/2 Set-2 extended-key scancode byte stream for the matching arrow key. The block is the transmit-side counterpart of the keyboard movement decoder: the decoder maps a 32-bit keycode history word to a movement, and this block produces that byte stream and the history word from a movement. It sits between game or test logic and any byte sink, such as a PS/2 device-side serializer or a loopback into the decoder.

## Interface
Parameters: none.

Clock and reset: one clock; reset is asynchronous and active-low.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mv_valid  in  1  movement command offered
- mv_ready  out  1  block can accept a command (high only in IDLE)
- movement  in  3  000 Right, 001 Up, 010 Left, 011 Down; 1xx illegal
- byte_valid  out  1  byte_data holds a valid scancode byte
- byte_ready  in  1  sink accepts byte_data this cycle
- byte_data  out  8  scancode byte
- keycode  out  32  history of accepted bytes, newest in [7:0]
- err  out  1  one-cycle pulse when an illegal movement is accepted

## Operation
- Scancode map: Right 0x74, Up 0x75, Left 0x6B, Down 0x72. Every one is prefixed with 0xE0.
- FSM states: IDLE, MK_E0, MK_CODE, BR_E0, BR_F0, BR_CODE.
- IDLE:
  - mv_ready=1.
  - On mv_valid with a legal movement: latch the code and go to MK_E0.
  - On mv_valid with an illegal movement: consume the command, pulse err the next cycle, stay in IDLE, emit no bytes.
- Non-IDLE states:
  - byte_valid=1 and mv_ready=0.
  - byte_data is MK_E0=0xE0, MK_CODE=code, BR_E0=0xE0, BR_F0=0xF0, BR_CODE=code.
  - The state advances only on byte_valid && byte_ready.
- Transitions: MK_E0→MK_CODE→BR_E0→BR_F0→BR_CODE→IDLE. When the break sequence is compiled out, MK_CODE→IDLE.
- keycode updates only on a handshake: keycode <= {keycode[23:0], byte_data}.
- Illegal movement and idle cycles leave keycode unchanged.

## Timing
- Reset values (asynchronous, all outputs): state IDLE, mv_ready=1, byte_valid=0, byte_data=0x00, keycode=0x00000000, err=0.
- Reset mid-sequence aborts the sequence. No partial break sequence is emitted after reset.
- Latency: a command accepted at edge N gives byte_valid=1 with 0xE0 after edge N.
- byte_data and byte_valid hold stable while byte_valid && !byte_ready.
- Backpressure of any length is legal.
- One byte per cycle maximum. With byte_ready held high, a full make+break sequence occupies 5 cycles.
- After the last byte's handshake at edge M, mv_ready=1 after edge M, so the next command can be accepted at edge M+1.
- mv_valid while mv_ready=0 is ignored. The source must hold the command.
- err is registered and high for exactly one cycle per illegal command.

## Configuration
- SCAN_BREAK_EN defined: each command emits make then break, E0 code E0 F0 code (5 bytes).
- SCAN_BREAK_EN undefined: each command emits make only, E0 code (2 bytes). BR_* states are absent and MK_CODE returns to IDLE.

## Structure
- Shared package snake_pkg holds:
  - movement encodings MV_RIGHT/MV_UP/MV_LEFT/MV_DOWN
  - scancode constants SC_EXT=0xE0, SC_BREAK=0xF0, SC_RIGHT, SC_UP, SC_LEFT, SC_DOWN
  - the FSM state typedef
- Sub-module mv_scancode_lut: combinational map from movement to {legal, code[7:0]}. It is instantiated once.

## Test plan
- Reset, then check idle outputs: mv_ready=1, byte_valid=0, keycode=0, err=0.
- Left, byte_ready held high, SCAN_BREAK_EN defined:
  - Stimulus: movement=010.
  - Response: bytes E0,6B,E0,F0,6B on consecutive cycles; final keycode=0x6BE0F06B; mv_ready=1 the cycle after.
- Up, SCAN_BREAK_EN undefined:
  - Stimulus: movement=001 from reset.
  - Response: bytes E0,75; keycode=0x0000E075.
- Down with backpressure:
  - Stimulus: movement=011; byte_ready low for 3 cycles on the 0x72 byte.
  - Response: byte_data stays 0x72 and byte_valid stays 1; keycode is unchanged until the handshake.
- Illegal then legal:
  - Stimulus: movement=101, then Right.
  - Response: err pulses once; no bytes for 101; Right emits E0,74,…; keycode reflects only the Right bytes.
- Reset mid-sequence:
  - Stimulus: rst_n low after the BR_E0 handshake.
  - Response: immediate IDLE with byte_valid=0 and keycode=0; no 0xF0 byte is emitted afterwards.
